// File: rtl/fpga_pio_pkg.sv
// Shared constants for the multi-channel PIO block: register map,
// capture-edge selection codes and the bus data width.
package fpga_pio_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_DIR       = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR    = 3'd5;
  localparam logic [2:0] ADDR_BLINK_EN  = 3'd6;
  localparam logic [2:0] ADDR_BLINK_DIV = 3'd7;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_BOTH    = 2;

endpackage

// File: rtl/pio_blink_timer.sv
// Blink phase generator: a down-counter that reloads from the divider at
// terminal count and toggles the phase, giving a half-period of div+1 cycles.
// A divider of zero parks the phase high and freezes the counter.
module pio_blink_timer
  import fpga_pio_pkg::*;
(
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [DATA_W-1:0] blink_div,
  input  logic              load,
  input  logic [DATA_W-1:0] load_value,
  output logic              blink_phase
);

  logic [DATA_W-1:0] cnt;

  // Counter and phase; a divider write restarts the sequence with phase high.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cnt         <= '0;
      blink_phase <= 1'b1;
    end else if (load) begin
      cnt         <= load_value;
      blink_phase <= 1'b1;
    end else if (blink_div == '0) begin
      blink_phase <= 1'b1;
    end else if (cnt == '0) begin
      cnt         <= blink_div;
      blink_phase <= ~blink_phase;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/fpga_pio_multi.sv
// Multi-channel PIO with per-bit direction, edge capture interrupts,
// set/clear output aliases and a shared blink modulator on outputs.
module fpga_pio_multi
  import fpga_pio_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] DIR_RESET = '1,
  parameter int               EDGE_TYPE = 0,
  parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              irq,
  input  logic [WIDTH-1:0]  pio_in,
  output logic [WIDTH-1:0]  pio_out,
  output logic [WIDTH-1:0]  pio_oe
);

  logic [WIDTH-1:0]  out_reg;
  logic [WIDTH-1:0]  dir_reg;
  logic [WIDTH-1:0]  irq_mask;
  logic [WIDTH-1:0]  edge_cap;
  logic [WIDTH-1:0]  blink_en;
  logic [DATA_W-1:0] blink_div;
  logic [WIDTH-1:0]  sync_meta;
  logic [WIDTH-1:0]  sync_in;
  logic [WIDTH-1:0]  sync_dly;
  logic [WIDTH-1:0]  edge_hit;
  logic [WIDTH-1:0]  cap_clr;
  logic [WIDTH-1:0]  wdata;
  logic [DATA_W-1:0] rd_mux;
  logic              blink_load;
  logic              blink_phase;

  assign wdata      = avs_writedata[WIDTH-1:0];
  assign blink_load = avs_write && (avs_address == ADDR_BLINK_DIV);
  assign cap_clr    = (avs_write && (avs_address == ADDR_EDGE_CAP)) ? wdata : '0;

  // Control registers; OUTSET/OUTCLR are write-only aliases onto out_reg.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      out_reg   <= OUT_RESET;
      dir_reg   <= DIR_RESET;
      irq_mask  <= '0;
      blink_en  <= '0;
      blink_div <= '0;
    end else if (avs_write) begin
      case (avs_address)
        ADDR_DATA:      out_reg   <= wdata;
        ADDR_DIR:       dir_reg   <= wdata;
        ADDR_IRQ_MASK:  irq_mask  <= wdata;
        ADDR_OUTSET:    out_reg   <= out_reg | wdata;
        ADDR_OUTCLR:    out_reg   <= out_reg & ~wdata;
        ADDR_BLINK_EN:  blink_en  <= wdata;
        ADDR_BLINK_DIV: blink_div <= avs_writedata;
        default: ;
      endcase
    end
  end

  // Two-flop synchroniser plus one delay flop for edge detection.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync_meta <= '0;
      sync_in   <= '0;
      sync_dly  <= '0;
    end else begin
      sync_meta <= pio_in;
      sync_in   <= sync_meta;
      sync_dly  <= sync_in;
    end
  end

  // Select which transitions count as a capture event.
  always_comb begin
    edge_hit = sync_in & ~sync_dly;
    case (EDGE_TYPE)
      EDGE_FALLING: edge_hit = ~sync_in & sync_dly;
      EDGE_BOTH:    edge_hit = sync_in ^ sync_dly;
      default:      edge_hit = sync_in & ~sync_dly;
    endcase
  end

  // Edge capture with W1C; a new edge on the same bit beats the clear.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~cap_clr) | (edge_hit & ~dir_reg);
    end
  end

  // Registered level interrupt from masked captures.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_cap & irq_mask);
    end
  end

  // Read mux; narrow registers are zero-extended to the bus width.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA:      rd_mux[WIDTH-1:0] = (out_reg & dir_reg) | (sync_in & ~dir_reg);
      ADDR_DIR:       rd_mux[WIDTH-1:0] = dir_reg;
      ADDR_IRQ_MASK:  rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAP:  rd_mux[WIDTH-1:0] = edge_cap;
      ADDR_BLINK_EN:  rd_mux[WIDTH-1:0] = blink_en;
      ADDR_BLINK_DIV: rd_mux            = blink_div;
      default:        rd_mux            = '0;
    endcase
  end

  // Read data is captured on the read strobe and held until the next read.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_mux;
    end
  end

  pio_blink_timer u_blink_timer (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .blink_div   (blink_div),
    .load        (blink_load),
    .load_value  (avs_writedata),
    .blink_phase (blink_phase)
  );

  assign pio_out = (out_reg & ~blink_en) | (out_reg & blink_en & {WIDTH{blink_phase}});
  assign pio_oe  = dir_reg;

endmodule
